// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_NINE  = 4'h9;

  // Decimal digits of 2^bin_w-1: floor(bin_w*log10(2))+1, since 2^n is never a power of ten.
  function automatic int unsigned digits_needed(input int unsigned bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;
  end

endmodule

// File: rtl/bcd_converter_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock.
// Optional leading-zero blanking on the bcd port when BCD_LZ_BLANK_EN is defined.
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  eo,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < digits_needed(BIN_W)) begin : g_digits_info
    $info("bcd_converter_seq: DIGITS too small for BIN_W, large operands saturate to all 9s");
  end

  state_t             r_state;
  logic [BIN_W-1:0]   r_sh;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_disp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sh       <= in_bin;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= CNT_W'(BIN_W);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // The cycle after the last shift applies saturation, so the sticky flag is complete.
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            if (r_ovf) begin
              r_acc <= {DIGITS{BCD_NINE}};
            end
          end else begin
            {r_acc, r_sh} <= {w_adj[ACC_W-2:0], r_sh, 1'b0};
            r_ovf         <= r_ovf | w_adj[ACC_W-1];
            r_cnt         <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BCD_LZ_BLANK_EN
  logic w_lead;

  always_comb begin
    w_disp = r_acc;
    w_lead = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (w_lead && (r_acc[4*i +: 4] == 4'h0)) begin
        w_disp[4*i +: 4] = BCD_BLANK;
      end else begin
        w_lead = 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_disp = r_acc;
  end
`endif

  always_comb begin
    bcd = eo ? '1 : w_disp;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq across three width/digit configurations.
module tb_bcd_converter_seq;

  localparam int unsigned BW [3] = '{8, 5, 8};
  localparam int unsigned ND [3] = '{3, 2, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        eo;
  logic        iv   [3];
  logic        ordy [3];
  logic [7:0]  ib   [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic        ovf  [3];
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [7:0]  bcd2;
  logic [11:0] bcdv [3];

  always_comb begin
    bcdv[0] = bcd0;
    bcdv[1] = {4'h0, bcd1};
    bcdv[2] = {4'h0, bcd2};
  end

  bcd_converter_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_bin(ib[0]),
    .out_valid(vld[0]), .out_ready(ordy[0]), .eo(eo), .bcd(bcd0), .overflow(ovf[0]));

  bcd_converter_seq #(.BIN_W(5), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_bin(ib[1][4:0]),
    .out_valid(vld[1]), .out_ready(ordy[1]), .eo(eo), .bcd(bcd1), .overflow(ovf[1]));

  bcd_converter_seq #(.BIN_W(8), .DIGITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_bin(ib[2]),
    .out_valid(vld[2]), .out_ready(ordy[2]), .eo(eo), .bcd(bcd2), .overflow(ovf[2]));

  int unsigned q  [3][$];
  int unsigned qc [3][$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  logic        pv [3] = '{1'b0, 1'b0, 1'b0};
  int unsigned mon_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits of the value, saturated to 10^nd-1, then display masks.
  function automatic logic [11:0] model_bcd(input int unsigned val, input int unsigned nd,
                                            input logic e);
    logic [11:0] r = '0;
    int unsigned lim = 1;
    int unsigned v;
    int unsigned p = 1;
    for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
    lim = lim - 1;
    v = (val > lim) ? lim : val;
    for (int unsigned i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
`ifdef BCD_LZ_BLANK_EN
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
      if (e) r[4*i +: 4] = 4'hF;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned val, input int unsigned nd);
    int unsigned lim = 1;
    for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
    return val > lim - 1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !pv[i]) begin
        if (qc[i].size() == 0) check($sformatf("output_without_request[%0d]", i), 0, 1);
        else check($sformatf("latency[%0d]", i), cyc - qc[i][0], BW[i] + 1);
      end
      if (vld[i] && ordy[i] && q[i].size() != 0) begin
        mon_v = q[i].pop_front();
        void'(qc[i].pop_front());
        check($sformatf("bcd[%0d] in=%0d", i, mon_v), bcdv[i], model_bcd(mon_v, ND[i], eo));
        check($sformatf("overflow[%0d] in=%0d", i, mon_v), ovf[i], model_ovf(mon_v, ND[i]));
      end
      pv[i] = vld[i];
    end
  end

  task automatic send(input int idx, input int unsigned val);
    int unsigned w = 0;
    @(negedge clk);
    while (!rdy[idx] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("in_ready_timeout", rdy[idx], 1);
    ib[idx] = 8'(val);
    iv[idx] = 1'b1;
    @(posedge clk);
    #1;
    q[idx].push_back(val);
    qc[idx].push_back(cyc);
    iv[idx] = 1'b0;
  endtask

  task automatic drain(input int idx);
    int unsigned w = 0;
    while (q[idx].size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", q[idx].size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    rst_n = 1'b0;
    eo    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; ib[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready", rdy[i], 1);
      check("reset_out_valid", vld[i], 0);
      check("reset_overflow", ovf[i], 0);
      check("reset_bcd", bcdv[i], model_bcd(0, ND[i], eo));
    end
    rst_n = 1'b1;

    send(0, 0);   drain(0);
    send(0, 255); drain(0);
    send(0, 37);  send(0, 200); drain(0);
    for (int k = 0; k < 20; k++) send(0, $urandom_range(255, 0));
    drain(0);

    for (int unsigned v = 0; v < 32; v++) send(1, v);
    drain(1);

    send(2, 200); send(2, 99); send(2, 100); send(2, 255);
    for (int k = 0; k < 10; k++) send(2, $urandom_range(255, 0));
    drain(2);

    // Hold the result in DONE with out_ready low; in_valid pulses and eo must not disturb it.
    ordy[0] = 1'b0;
    send(0, 123);
    w = 0;
    while (!vld[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("done_reached", vld[0], 1);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", vld[0], 1);
      check("hold_in_ready", rdy[0], 0);
      check("hold_bcd", bcd0, model_bcd(123, 3, eo));
      check("hold_overflow", ovf[0], 0);
      if (k == 1) begin iv[0] = 1'b1; ib[0] = 8'd55; end
      if (k == 2) begin iv[0] = 1'b0; eo = 1'b1; end
      if (k == 3) eo = 1'b0;
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    drain(0);
    repeat (15) @(negedge clk);

    send(0, 77);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", vld[0], 0);
    check("abort_in_ready", rdy[0], 1);
    check("abort_overflow", ovf[0], 0);
    check("abort_bcd", bcd0, model_bcd(0, 3, eo));
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      qc[i].delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 128); drain(0);
    send(0, 7);   drain(0);
    send(0, 90);  drain(0);

    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
